// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern codes and default 640x480 timing.
package vga_pkg;

  typedef enum logic [2:0] {
    PAT_BLACK  = 3'd0,
    PAT_RED    = 3'd1,
    PAT_GRN    = 3'd2,
    PAT_BLU    = 3'd3,
    PAT_CHECK  = 3'd4,
    PAT_BARS   = 3'd5,
    PAT_BORDER = 3'd6,
    PAT_BOX    = 3'd7
  } pattern_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

endpackage

// File: rtl/vga_timing_core.sv
// Raster counters plus registered sync/DE/coordinate decode (one cycle behind the counters).
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int CW      = $clog2(H_TOTAL),
  localparam int RW      = $clog2(V_TOTAL)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  output logic [CW-1:0] o_Cnt_Col,
  output logic [RW-1:0] o_Cnt_Row,
  output logic          o_Wrap,
  output logic          o_HSync,
  output logic          o_VSync,
  output logic          o_DE,
  output logic [CW-1:0] o_Col,
  output logic [RW-1:0] o_Row,
  output logic          o_Frame_Start
);

  logic [CW-1:0] col_q, col_d, ocol_q;
  logic [RW-1:0] row_q, row_d, orow_q;
  logic          hs_q, vs_q, de_q, fs_q;
  logic          col_last, row_last, hs_act, vs_act, de_act;

  assign col_last = (col_q == CW'(H_TOTAL - 1));
  assign row_last = (row_q == RW'(V_TOTAL - 1));

  always_comb begin
    col_d = col_last ? '0 : col_q + CW'(1);
    row_d = row_q;
    if (col_last) row_d = row_last ? '0 : row_q + RW'(1);
  end

  assign hs_act = (col_q >= CW'(H_ACTIVE + H_FRONT)) &&
                  (col_q <= CW'(H_ACTIVE + H_FRONT + H_SYNC - 1));
  assign vs_act = (row_q >= RW'(V_ACTIVE + V_FRONT)) &&
                  (row_q <= RW'(V_ACTIVE + V_FRONT + V_SYNC - 1));
  assign de_act = (col_q < CW'(H_ACTIVE)) && (row_q < RW'(V_ACTIVE));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_q  <= '0;
      row_q  <= '0;
      ocol_q <= '0;
      orow_q <= '0;
      hs_q   <= ~H_POL;
      vs_q   <= ~V_POL;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      ocol_q <= col_q;
      orow_q <= row_q;
      hs_q   <= hs_act ? H_POL : ~H_POL;
      vs_q   <= vs_act ? V_POL : ~V_POL;
      de_q   <= de_act;
      fs_q   <= (col_q == '0) && (row_q == '0);
    end
  end

  // o_Wrap marks the edge on which the counters move to (0,0).
  assign o_Wrap        = col_last && row_last;
  assign o_Cnt_Col     = col_q;
  assign o_Cnt_Row     = row_q;
  assign o_HSync       = hs_q;
  assign o_VSync       = vs_q;
  assign o_DE          = de_q;
  assign o_Col         = ocol_q;
  assign o_Row         = orow_q;
  assign o_Frame_Start = fs_q;

endmodule

// File: rtl/vga_video_engine.sv
// VGA test-pattern engine: timing core plus pattern select/colour generation.
// VGA_BOUNCE_BOX_EN enables the bouncing-box pattern (code 7); otherwise code 7 is black.
module vga_video_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int VIDEO_W   = 3,
  parameter int TILE_LOG2 = 5,
  parameter int BOX_SIZE  = 32,
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int CW       = $clog2(H_TOTAL),
  localparam int RW       = $clog2(V_TOTAL)
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Pattern_DV,
  input  logic [2:0]         i_Pattern_Sel,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_DE,
  output logic [CW-1:0]      o_Col,
  output logic [RW-1:0]      o_Row,
  output logic               o_Frame_Start,
  output logic [VIDEO_W-1:0] o_Red,
  output logic [VIDEO_W-1:0] o_Grn,
  output logic [VIDEO_W-1:0] o_Blu
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [VIDEO_W-1:0] FULL = '1;

  logic [CW-1:0] cnt_col;
  logic [RW-1:0] cnt_row;
  logic          wrap;

  vga_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .H_POL(H_POL), .V_POL(V_POL)
  ) u_timing (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L),
    .o_Cnt_Col(cnt_col), .o_Cnt_Row(cnt_row), .o_Wrap(wrap),
    .o_HSync(o_HSync), .o_VSync(o_VSync), .o_DE(o_DE),
    .o_Col(o_Col), .o_Row(o_Row), .o_Frame_Start(o_Frame_Start)
  );

  pattern_e pend_q, pend_d, act_q, act_d;

  // Active takes the pending value held before this edge, so a strobe on the wrap edge waits a frame.
  always_comb begin
    pend_d = i_Pattern_DV ? pattern_e'(i_Pattern_Sel) : pend_q;
    act_d  = wrap ? pend_q : act_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pend_q <= PAT_BLACK;
      act_q  <= PAT_BLACK;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

`ifdef VGA_BOUNCE_BOX_EN
  logic [CW-1:0] bx_q, bx_d;
  logic [RW-1:0] by_q, by_d;
  logic          dx_q, dx_d, dy_q, dy_d;
  logic          in_box;

  // dx/dy = 1 means moving toward larger coordinates.
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (wrap) begin
      if (dx_q && (int'(bx_q) + BOX_SIZE >= H_ACTIVE)) begin
        dx_d = 1'b0;
        bx_d = bx_q - CW'(1);
      end else if (!dx_q && (bx_q == '0)) begin
        dx_d = 1'b1;
        bx_d = bx_q + CW'(1);
      end else begin
        bx_d = dx_q ? bx_q + CW'(1) : bx_q - CW'(1);
      end
      if (dy_q && (int'(by_q) + BOX_SIZE >= V_ACTIVE)) begin
        dy_d = 1'b0;
        by_d = by_q - RW'(1);
      end else if (!dy_q && (by_q == '0)) begin
        dy_d = 1'b1;
        by_d = by_q + RW'(1);
      end else begin
        by_d = dy_q ? by_q + RW'(1) : by_q - RW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bx_q <= '0;
      by_q <= '0;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign in_box = (cnt_col >= bx_q) && (int'(cnt_col) < int'(bx_q) + BOX_SIZE) &&
                  (cnt_row >= by_q) && (int'(cnt_row) < int'(by_q) + BOX_SIZE);
`endif

  logic [VIDEO_W-1:0] red_d, grn_d, blu_d, red_q, grn_q, blu_q;
  logic [2:0]         bar_k;
  logic               de_now, on_border;

  always_comb begin
    bar_k = 3'd0;
    for (int i = 1; i < 8; i++)
      if (int'(cnt_col) >= i * BAR_W) bar_k = 3'(i);
    de_now    = (cnt_col < CW'(H_ACTIVE)) && (cnt_row < RW'(V_ACTIVE));
    on_border = (cnt_col == '0) || (cnt_col == CW'(H_ACTIVE - 1)) ||
                (cnt_row == '0) || (cnt_row == RW'(V_ACTIVE - 1));
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (de_now) begin
      case (act_q)
        PAT_RED: red_d = FULL;
        PAT_GRN: grn_d = FULL;
        PAT_BLU: blu_d = FULL;
        PAT_CHECK:
          if (cnt_col[TILE_LOG2] ^ cnt_row[TILE_LOG2]) {red_d, grn_d, blu_d} = {3{FULL}};
        PAT_BARS: begin
          red_d = {VIDEO_W{bar_k[0]}};
          grn_d = {VIDEO_W{bar_k[1]}};
          blu_d = {VIDEO_W{bar_k[2]}};
        end
        PAT_BORDER:
          if (on_border) {red_d, grn_d, blu_d} = {3{FULL}};
`ifdef VGA_BOUNCE_BOX_EN
        PAT_BOX:
          if (in_box) {red_d, grn_d, blu_d} = {3{FULL}};
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
    end
  end

  assign o_Red = red_q;
  assign o_Grn = grn_q;
  assign o_Blu = blu_q;

endmodule

// File: tb/tb_vga_video_engine.sv
// Bench for vga_video_engine on a shrunken raster (48x18 total, 32x12 active) to keep frames short.
module tb_vga_video_engine;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 2;
  localparam bit HP = 1'b1, VP = 1'b0;
  localparam int VW = 3, TL = 2, BS = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CW = $clog2(HT);
  localparam int RW = $clog2(VT);
  localparam int VWID = 4 + CW + RW + 3 * VW;
`ifdef VGA_BOUNCE_BOX_EN
  localparam bit BOX_EN = 1'b1;
`else
  localparam bit BOX_EN = 1'b0;
`endif
  localparam int WHITE = 511;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dv = 1'b0;
  logic [2:0]    sel = 3'd0;
  logic          hs, vs, de, fs;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [VW-1:0] red, grn, blu;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vga_video_engine #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_POL(HP), .V_POL(VP), .VIDEO_W(VW), .TILE_LOG2(TL), .BOX_SIZE(BS)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pattern_DV(dv), .i_Pattern_Sel(sel),
    .o_HSync(hs), .o_VSync(vs), .o_DE(de), .o_Col(col), .o_Row(row),
    .o_Frame_Start(fs), .o_Red(red), .o_Grn(grn), .o_Blu(blu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int tri_pos(input int f, input int m);
    int p;
    if (m <= 0) return 0;
    p = f % (2 * m);
    return (p <= m) ? p : 2 * m - p;
  endfunction

  function automatic logic [3*VW-1:0] exp_rgb(input int c, input int r, input logic [2:0] p, input int f);
    int k, bx, by;
    if (!(c < HA && r < VA)) return '0;
    case (p)
      3'd1: return 9'o700;
      3'd2: return 9'o070;
      3'd3: return 9'o007;
      3'd4: return ((((c >> TL) ^ (r >> TL)) & 1) != 0) ? 9'o777 : 9'o000;
      3'd5: begin
        k = c * 8 / HA;
        return {{3{k[0]}}, {3{k[1]}}, {3{k[2]}}};
      end
      3'd6: return (c == 0 || c == HA - 1 || r == 0 || r == VA - 1) ? 9'o777 : 9'o000;
      3'd7: begin
        bx = tri_pos(f, HA - BS);
        by = tri_pos(f, VA - BS);
        return (BOX_EN && c >= bx && c < bx + BS && r >= by && r < by + BS) ? 9'o777 : 9'o000;
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic [VWID-1:0] exp_vec(input int c, input int r, input logic [2:0] p, input int f);
    logic hsv, vsv, dev, fsv;
    hsv = (c >= HA + HF && c < HA + HF + HS) ? HP : !HP;
    vsv = (r >= VA + VF && r < VA + VF + VS) ? VP : !VP;
    dev = (c < HA) && (r < VA);
    fsv = (c == 0) && (r == 0);
    return {hsv, vsv, dev, CW'(c), RW'(r), fsv, exp_rgb(c, r, p, f)};
  endfunction

  logic [VWID-1:0] act_vec, rst_vec, want;
  assign act_vec = {hs, vs, de, col, row, fs, red, grn, blu};
  assign rst_vec = {!HP, !VP, 1'b0, CW'(0), RW'(0), 1'b0, 9'd0};

  int ec = 0, er = 0, fidx = 0, nc, nr;
  bit started = 0;
  logic [2:0] m_pend = 3'd0, m_act = 3'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (act_vec !== rst_vec) begin
        failures++;
        $display("FAIL reset_state: got %h expected %h", act_vec, rst_vec);
      end
      started = 0; m_pend = 3'd0; m_act = 3'd0; fidx = 0;
    end else if (!started) begin
      checks++;
      if (act_vec !== rst_vec) begin
        failures++;
        $display("FAIL post_release_hold: got %h expected %h", act_vec, rst_vec);
      end
      if (dv) m_pend = sel;
      started = 1; ec = 0; er = 0;
    end else begin
      want = exp_vec(ec, er, m_act, fidx);
      checks++;
      if (act_vec !== want) begin
        failures++;
        $display("FAIL pixel (%0d,%0d) pat %0d: got %h expected %h", ec, er, m_act, act_vec, want);
      end
      nc = ec + 1; nr = er;
      if (nc == HT) begin
        nc = 0; nr = er + 1;
        if (nr == VT) nr = 0;
      end
      if (nc == HT - 1 && nr == VT - 1) begin
        m_act = m_pend;
        fidx++;
      end
      if (dv) m_pend = sel;
      ec = nc; er = nr;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_xy(input int c, input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(col) == c && int'(row) == r) && n < 2000);
    if (n >= 2000) chk("wait_xy_timeout", n, 0);
  endtask

  task automatic next_frame();
    wait_xy(0, 0);
  endtask

  task automatic strobe(input logic [2:0] s);
    @(posedge clk); #1;
    dv = 1'b1; sel = s;
    @(posedge clk); #1;
    dv = 1'b0;
  endtask

  function automatic int rgb_now();
    return int'({red, grn, blu});
  endfunction

  int t0, n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", int'(hs), 0);
    chk("rst_vsync", int'(vs), 1);
    chk("rst_de", int'(de), 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("first_fs", int'(fs), 1);
    chk("first_col", int'(col), 0);
    chk("first_row", int'(row), 0);
    t0 = cyc;

    n = 0;
    while (!hs && n < 200) begin @(negedge clk); n++; end
    chk("hsync_start_col", int'(col), HA + HF);
    n = 0;
    while (hs && n < 200) begin @(negedge clk); n++; end
    chk("hsync_width", n, HS);
    wait_xy(0, 1);
    chk("line_period", cyc - t0, HT);
    next_frame();
    chk("frame_period", cyc - t0, HT * VT);

    // frame 1: blue requested mid-frame
    wait_xy(0, 5);
    strobe(3'd3);
    wait_xy(5, 6);
    chk("blue_not_yet", rgb_now(), 0);
    next_frame();
    wait_xy(5, 0);
    chk("blue_active", rgb_now(), 7);
    wait_xy(40, 0);
    chk("blue_blank", rgb_now(), 0);

    // checker
    strobe(3'd4);
    next_frame();
    wait_xy(3, 0);
    chk("chk_3_0", rgb_now(), 0);
    wait_xy(4, 0);
    chk("chk_4_0", rgb_now(), WHITE);
    wait_xy(4, 4);
    chk("chk_4_4", rgb_now(), 0);

    // last-wins, then strobe on the wrap edge
    strobe(3'd4);
    strobe(3'd5);
    wait_xy(HT - 3, VT - 1);
    strobe(3'd1);
    wait_xy(4, 2);
    chk("bar1_red", rgb_now(), 9'o700);
    wait_xy(8, 2);
    chk("bar2_grn", rgb_now(), 9'o070);
    next_frame();
    wait_xy(10, 3);
    chk("red_after_wrap", rgb_now(), 9'o700);

    strobe(3'd6);
    next_frame();
    wait_xy(0, 5);
    chk("border_left", rgb_now(), WHITE);
    wait_xy(5, 5);
    chk("border_inner", rgb_now(), 0);
    wait_xy(HA - 1, 5);
    chk("border_right", rgb_now(), WHITE);
    wait_xy(5, VA - 1);
    chk("border_bottom", rgb_now(), WHITE);

    strobe(3'd2);
    next_frame();
    wait_xy(7, 7);
    chk("green", rgb_now(), 9'o070);

    // reset mid-line while hsync is asserted
    wait_xy(HA + HF + 1, 8);
    @(posedge clk); #1;
    chk("hsync_before_rst", int'(hs), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_hsync", int'(hs), 0);
    chk("rst_async_col", int'(col), 0);
    chk("rst_async_de", int'(de), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rerelease_col", int'(col), 0);
    chk("rerelease_fs", int'(fs), 1);

    // bouncing box
    strobe(3'd7);
    next_frame();
    chk("box_f1_0_0", rgb_now(), 0);
    wait_xy(1, 1);
    chk("box_f1_1_1", rgb_now(), BOX_EN ? WHITE : 0);
    wait_xy(8, 8);
    chk("box_f1_8_8", rgb_now(), BOX_EN ? WHITE : 0);
    wait_xy(9, 9);
    chk("box_f1_9_9", rgb_now(), 0);
    next_frame();
    wait_xy(1, 1);
    chk("box_f2_1_1", rgb_now(), 0);
    wait_xy(2, 2);
    chk("box_f2_2_2", rgb_now(), BOX_EN ? WHITE : 0);
    repeat (22) next_frame();
    wait_xy(23, 0);
    chk("box_f24_23_0", rgb_now(), 0);
    wait_xy(31, 0);
    chk("box_f24_31_0", rgb_now(), BOX_EN ? WHITE : 0);
    next_frame();
    wait_xy(23, 1);
    chk("box_f25_23_1", rgb_now(), BOX_EN ? WHITE : 0);
    wait_xy(31, 1);
    chk("box_f25_31_1", rgb_now(), 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
